// File: rtl/pid_core_param.sv
// Purpose: parameterised fixed-point PID controller (P, saturating I, D terms) on unsigned samples.
// Latency: sample accepted at edge k, control/flags registered and out_valid pulses one cycle at k+3.
// Backpressure: in_ready high only in IDLE; in_valid is ignored while a sample is in flight.
//
// Ports: clk/rst_n (async active-low); setpoint/feedback + in_valid/in_ready sample handshake;
//        gain_we/gain_sel/gain_data gain write (sel 0=Kp 1=Ki 2=Kd, 3 ignored); clr_int clears
//        integrator and error history; control/out_valid/sat_hi/sat_lo result (held between pulses).
// Build option: define PID_DERIV_FILTER_EN to low-pass the derivative error difference.
module pid_core_param #(
  parameter int DW     = 8,
  parameter int GW     = 8,
  parameter int FRAC   = 2,
  parameter int IW     = 16,
  parameter int KP_RST = 8,
  parameter int KI_RST = 0,
  parameter int KD_RST = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] setpoint,
  input  logic [DW-1:0] feedback,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          gain_we,
  input  logic [1:0]    gain_sel,
  input  logic [GW-1:0] gain_data,
  input  logic          clr_int,
  output logic [DW-1:0] control,
  output logic          out_valid,
  output logic          sat_hi,
  output logic          sat_lo
);

  localparam int EW  = DW + 1;                          // signed error
  localparam int XW  = DW + 2;                          // signed error difference
  localparam int XW1 = XW + 1;
  localparam int PW  = EW + GW + 1;                     // error * zero-extended gain
  localparam int DPW = XW + GW + 1;                     // difference * zero-extended gain
  localparam int AW  = ((IW > PW) ? IW : PW) + 1;       // integrator add, no overflow
  localparam int SW  = ((AW > DPW) ? AW : DPW) + 2;     // three-term sum, no overflow

  localparam logic signed [IW-1:0] IMAX = {1'b0, {(IW-1){1'b1}}};
  localparam logic signed [IW-1:0] IMIN = {1'b1, {(IW-1){1'b0}}};
  localparam logic signed [SW-1:0] CMAX = SW'({DW{1'b1}});

  typedef enum logic [1:0] {IDLE, ERR, ACC, OUT} state_t;

  typedef struct packed {
    logic [GW-1:0] kp;
    logic [GW-1:0] ki;
    logic [GW-1:0] kd;
  } gains_t;

  state_t                state_q, state_d;
  logic [DW-1:0]         sp_q, sp_d, fb_q, fb_d;
  gains_t                gains_q, gains_d, shadow_q, shadow_d;
  logic signed [EW-1:0]  err_q, err_d, prev_q, prev_d;
  logic signed [IW-1:0]  integ_q, integ_d;
  logic signed [PW-1:0]  p_q, p_d;
  logic signed [DPW-1:0] d_q, d_d;
  logic [DW-1:0]         control_q, control_d;
  logic                  out_valid_q, out_valid_d;
  logic                  sat_hi_q, sat_hi_d, sat_lo_q, sat_lo_d;

  logic signed [GW:0]    kp_s, ki_s, kd_s;
  logic signed [XW-1:0]  diff;
  logic signed [PW-1:0]  p_calc, ki_prod;
  logic signed [DPW-1:0] d_calc;
  logic signed [AW-1:0]  integ_sum;
  logic signed [IW-1:0]  integ_sat;
  logic signed [SW-1:0]  sum, sum_sh;
`ifdef PID_DERIV_FILTER_EN
  logic signed [XW-1:0]  df_q, df_d, df_new;
  logic signed [XW1-1:0] df_step, df_acc;
`endif

  assign in_ready  = (state_q == IDLE);
  assign control   = control_q;
  assign out_valid = out_valid_q;
  assign sat_hi    = sat_hi_q;
  assign sat_lo    = sat_lo_q;

  always_comb begin
    // Arithmetic always uses the gain snapshot taken at acceptance.
    kp_s      = $signed({1'b0, shadow_q.kp});
    ki_s      = $signed({1'b0, shadow_q.ki});
    kd_s      = $signed({1'b0, shadow_q.kd});
    diff      = XW'(err_q) - XW'(prev_q);
    p_calc    = PW'(err_q) * PW'(kp_s);
    ki_prod   = PW'(err_q) * PW'(ki_s);
    integ_sum = AW'(integ_q) + AW'(ki_prod);
    if (integ_sum > AW'(IMAX))      integ_sat = IMAX;
    else if (integ_sum < AW'(IMIN)) integ_sat = IMIN;
    else                            integ_sat = integ_sum[IW-1:0];
`ifdef PID_DERIV_FILTER_EN
    // First-order IIR with weight 1/4 on the new difference.
    df_step = XW1'(diff) - XW1'(df_q);
    df_acc  = XW1'(df_q) + (df_step >>> 2);
    df_new  = df_acc[XW-1:0];
    d_calc  = DPW'(df_new) * DPW'(kd_s);
`else
    d_calc  = DPW'(diff) * DPW'(kd_s);
`endif
    // integ_q already holds this sample's updated integrator when OUT reads it.
    sum    = SW'(p_q) + SW'(integ_q) + SW'(d_q);
    sum_sh = sum >>> FRAC;
  end

  always_comb begin
    state_d     = state_q;
    sp_d        = sp_q;
    fb_d        = fb_q;
    gains_d     = gains_q;
    shadow_d    = shadow_q;
    err_d       = err_q;
    prev_d      = prev_q;
    integ_d     = integ_q;
    p_d         = p_q;
    d_d         = d_q;
    control_d   = control_q;
    out_valid_d = 1'b0;
    sat_hi_d    = sat_hi_q;
    sat_lo_d    = sat_lo_q;
`ifdef PID_DERIV_FILTER_EN
    df_d        = df_q;
`endif

    if (gain_we) begin
      case (gain_sel)
        2'd0:    gains_d.kp = gain_data;
        2'd1:    gains_d.ki = gain_data;
        2'd2:    gains_d.kd = gain_data;
        default: ;
      endcase
    end

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sp_d     = setpoint;
          fb_d     = feedback;
          shadow_d = gains_q;   // pre-write value if a write lands on the same edge
          state_d  = ERR;
        end
      end
      ERR: begin
        err_d   = $signed({1'b0, sp_q}) - $signed({1'b0, fb_q});
        state_d = ACC;
      end
      ACC: begin
        p_d     = p_calc;
        d_d     = d_calc;
        prev_d  = err_q;
        integ_d = integ_sat;
`ifdef PID_DERIV_FILTER_EN
        df_d    = df_new;
`endif
        state_d = OUT;
      end
      OUT: begin
        out_valid_d = 1'b1;
        if (sum_sh < 0) begin
          control_d = '0;
          sat_hi_d  = 1'b0;
          sat_lo_d  = 1'b1;
        end else if (sum_sh > CMAX) begin
          control_d = {DW{1'b1}};
          sat_hi_d  = 1'b1;
          sat_lo_d  = 1'b0;
        end else begin
          control_d = sum_sh[DW-1:0];
          sat_hi_d  = 1'b0;
          sat_lo_d  = 1'b0;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Clear wins over a same-cycle ACC update.
    if (clr_int) begin
      integ_d = '0;
      prev_d  = '0;
`ifdef PID_DERIV_FILTER_EN
      df_d    = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sp_q        <= '0;
      fb_q        <= '0;
      gains_q     <= '{kp: GW'(KP_RST), ki: GW'(KI_RST), kd: GW'(KD_RST)};
      shadow_q    <= '{kp: GW'(KP_RST), ki: GW'(KI_RST), kd: GW'(KD_RST)};
      err_q       <= '0;
      prev_q      <= '0;
      integ_q     <= '0;
      p_q         <= '0;
      d_q         <= '0;
      control_q   <= '0;
      out_valid_q <= 1'b0;
      sat_hi_q    <= 1'b0;
      sat_lo_q    <= 1'b0;
`ifdef PID_DERIV_FILTER_EN
      df_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sp_q        <= sp_d;
      fb_q        <= fb_d;
      gains_q     <= gains_d;
      shadow_q    <= shadow_d;
      err_q       <= err_d;
      prev_q      <= prev_d;
      integ_q     <= integ_d;
      p_q         <= p_d;
      d_q         <= d_d;
      control_q   <= control_d;
      out_valid_q <= out_valid_d;
      sat_hi_q    <= sat_hi_d;
      sat_lo_q    <= sat_lo_d;
`ifdef PID_DERIV_FILTER_EN
      df_q        <= df_d;
`endif
    end
  end

endmodule

// File: tb/tb_pid_core_param.sv
// Purpose: self-checking bench for pid_core_param at default parameters (filter off).
// Latency: expects out_valid four falling edges after the accepting rising edge.
// Backpressure: waits (bounded) for in_ready before presenting each sample.
module tb_pid_core_param;

  localparam int DW = 8;
  localparam int GW = 8;
  localparam int FRAC = 2;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] setpoint = '0;
  logic [DW-1:0] feedback = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          gain_we = 1'b0;
  logic [1:0]    gain_sel = '0;
  logic [GW-1:0] gain_data = '0;
  logic          clr_int = 1'b0;
  logic [DW-1:0] control;
  logic          out_valid;
  logic          sat_hi;
  logic          sat_lo;

  pid_core_param dut (
    .clk(clk), .rst_n(rst_n), .setpoint(setpoint), .feedback(feedback),
    .in_valid(in_valid), .in_ready(in_ready), .gain_we(gain_we), .gain_sel(gain_sel),
    .gain_data(gain_data), .clr_int(clr_int), .control(control), .out_valid(out_valid),
    .sat_hi(sat_hi), .sat_lo(sat_lo)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    longint ctrl;
    bit     hi;
    bit     lo;
    int     due;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   held;
  int     neg_cnt = 0;
  longint m_kp = 8, m_ki = 0, m_kd = 0;
  longint m_integ = 0, m_prev = 0;

  task automatic model_reset();
    exp_q.delete();
    held.ctrl = 0; held.hi = 0; held.lo = 0; held.due = 0;
    m_kp = 8; m_ki = 0; m_kd = 0;
    m_integ = 0; m_prev = 0;
  endtask

  task automatic model_accept(input int sp, input int fb);
    longint err, s;
    exp_t   e;
    err = longint'(sp) - longint'(fb);
    m_integ = m_integ + m_ki * err;
    if (m_integ > 32767)  m_integ = 32767;
    if (m_integ < -32768) m_integ = -32768;
    s = m_kp * err + m_integ + m_kd * (err - m_prev);
    m_prev = err;
    s = s >>> FRAC;
    e.hi = (s > 255);
    e.lo = (s < 0);
    e.ctrl = e.lo ? 0 : (e.hi ? 255 : s);
    e.due = neg_cnt + 4;
    exp_q.push_back(e);
  endtask

  task automatic model_gain(input int sel, input int val);
    case (sel)
      0: m_kp = val;
      1: m_ki = val;
      2: m_kd = val;
      default: ;
    endcase
  endtask

  // ---------------- cycle-by-cycle compare ----------------
  initial begin
    held.ctrl = 0; held.hi = 0; held.lo = 0; held.due = 0;
    forever begin
      @(negedge clk);
      neg_cnt++;
      if (exp_q.size() > 0 && exp_q[0].due == neg_cnt) begin
        held = exp_q.pop_front();
        chk("cmp_out_valid", longint'(out_valid), 1);
      end else begin
        chk("cmp_out_valid", longint'(out_valid), 0);
      end
      chk("cmp_control", longint'(control), held.ctrl);
      chk("cmp_sat_hi", longint'(sat_hi), longint'(held.hi));
      chk("cmp_sat_lo", longint'(sat_lo), longint'(held.lo));
    end
  end

  // ---------------- stimulus helpers (entered at posedge+1) ----------------
  task automatic write_gain(input int sel, input int val);
    gain_we = 1'b1; gain_sel = 2'(sel); gain_data = GW'(val);
    @(posedge clk);
    model_gain(sel, val);
    #1 gain_we = 1'b0;
  endtask

  task automatic clear_int();
    clr_int = 1'b1;
    @(posedge clk);
    m_integ = 0; m_prev = 0;
    #1 clr_int = 1'b0;
  endtask

  // Inputs are scrambled and in_valid held through ERR/ACC to show they are ignored.
  task automatic sample(input string nm, input int sp, input int fb, input int ec,
                        input bit eh, input bit el,
                        input bit mw = 1'b0, input int msel = 0, input int mval = 0);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk({nm, "_ready"}, longint'(in_ready), 1);
    setpoint = DW'(sp); feedback = DW'(fb); in_valid = 1'b1;
    @(posedge clk);
    model_accept(sp, fb);
    #1;
    setpoint = 8'hA5; feedback = 8'h3C;
    if (mw) begin
      gain_we = 1'b1; gain_sel = 2'(msel); gain_data = GW'(mval);
    end
    @(posedge clk);
    if (mw) model_gain(msel, mval);
    #1 gain_we = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk({nm, "_vld"}, longint'(out_valid), 1);
    chk({nm, "_ctrl"}, longint'(control), ec);
    chk({nm, "_hi"}, longint'(sat_hi), longint'(eh));
    chk({nm, "_lo"}, longint'(sat_lo), longint'(el));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int pulses;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_control", longint'(control), 0);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_sat_hi", longint'(sat_hi), 0);
    chk("rst_sat_lo", longint'(sat_lo), 0);
    rst_n = 1'b1;
    #1 chk("rst_release_ready", longint'(in_ready), 1);
    @(posedge clk); #1;

    // Proportional path and output saturation.
    sample("p_basic", 100, 60, 80, 0, 0);
    sample("p_sat_hi", 200, 0, 255, 1, 0);
    sample("p_sat_lo", 10, 50, 0, 0, 1);
    sample("p_small", 3, 0, 6, 0, 0);
    write_gain(3, 99);
    sample("sel3_ignored", 100, 60, 80, 0, 0);

    // Integrator accumulation and clear.
    write_gain(0, 0);
    write_gain(1, 4);
    clear_int();
    sample("i_1", 10, 0, 10, 0, 0);
    sample("i_2", 10, 0, 20, 0, 0);
    sample("i_3", 10, 0, 30, 0, 0);
    clear_int();
    sample("i_clr", 10, 0, 10, 0, 0);

    // Integrator clamp at both limits.
    write_gain(1, 255);
    clear_int();
    sample("i_clamp_hi", 255, 0, 255, 1, 0);
    chk("integ_max", longint'(dut.integ_q), 32767);
    sample("i_dn_1", 0, 255, 0, 0, 1);
    sample("i_dn_2", 0, 255, 0, 0, 1);
    chk("integ_min", longint'(dut.integ_q), -32768);

    // Derivative path; Kd write during ERR applies only to later samples.
    write_gain(1, 0);
    write_gain(2, 4);
    clear_int();
    sample("d_0", 0, 0, 0, 0, 0);
    sample("d_20", 20, 0, 20, 0, 0, 1'b1, 2, 255);
    sample("d_20b", 20, 0, 0, 0, 0);
    sample("d_21", 21, 0, 63, 0, 0);

    // Reset while the sample sits in ACC.
    setpoint = 8'd100; feedback = 8'd60; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("abort_ready", longint'(in_ready), 1);
    pulses = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    chk("abort_no_pulse", longint'(pulses), 0);
    chk("abort_control", longint'(control), 0);
    sample("post_reset", 100, 60, 80, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", longint'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pid_core_param.md
PID_CORE_PARAM -- requirements
Module: pid_core_param

Interface
REQ-001 SHALL have parameter DW, default 8: setpoint/feedback/control width, unsigned.
REQ-002 SHALL have parameter GW, default 8: gain width, unsigned.
REQ-003 SHALL have parameter FRAC, default 2: fractional bits of every gain.
REQ-004 SHALL have parameter IW, default 16: signed integrator width.
REQ-005 SHALL have parameters KP_RST=8, KI_RST=0, KD_RST=0: gain reset values.
REQ-006 SHALL have port clk  in  1  clock, all state on rising edge.
REQ-007 SHALL have port rst_n  in  1  reset; asynchronous, active-low.
REQ-008 SHALL have ports setpoint, feedback  in  DW  sample operands.
REQ-009 SHALL have ports in_valid in 1 and in_ready out 1: sample handshake.
REQ-010 SHALL have ports gain_we in 1, gain_sel in 2, gain_data in GW: gain write port.
REQ-011 SHALL have port clr_int  in  1  synchronous integrator/history clear.
REQ-012 SHALL have ports control out DW, out_valid out 1, sat_hi out 1, sat_lo out 1.

Function
REQ-013 SHALL use FSM IDLE->ERR->ACC->OUT->IDLE, one state per cycle; in_ready=1 only in IDLE.
REQ-014 SHALL accept a sample when in_valid&&in_ready at edge k; out_valid=1 in cycle k+3, exactly one cycle.
REQ-015 SHALL hold control, sat_hi, sat_lo constant between out_valid pulses.
REQ-016 SHALL compute err = setpoint - feedback as signed DW+1 bits, both operands zero-extended.
REQ-017 SHALL latch Kp/Ki/Kd shadow copies at acceptance; gain writes during ERR/ACC/OUT affect only later samples.
REQ-018 SHALL write gain_sel 0/1/2 to Kp/Ki/Kd on gain_we; gain_sel 3 is ignored.
REQ-019 SHALL compute P = Kp*err and D = Kd*(err - prev_err), full precision signed, then prev_err <= err.
REQ-020 SHALL update integ <= sat_IW(integ + Ki*err), clamped to [-2^(IW-1), 2^(IW-1)-1].
REQ-021 SHALL compute sum = (P + integ + D) >>> FRAC (arithmetic shift, floor).
REQ-022 SHALL drive control = 0 with sat_lo=1 if sum<0, 2^DW-1 with sat_hi=1 if sum>2^DW-1, else sum[DW-1:0] with both flags 0.
REQ-023 SHALL, on clr_int, zero integ and prev_err next edge; clr_int has priority over an ACC update in the same cycle.
REQ-024 SHALL ignore in_valid outside IDLE; setpoint/feedback are sampled only at acceptance.

Reset
REQ-025 SHALL on rst_n low: state IDLE, control=0, out_valid=0, sat_hi=0, sat_lo=0, integ=0, prev_err=0, gains=*_RST.
REQ-026 SHALL abort any in-flight sample on reset; no out_valid for it after release.
REQ-027 SHALL have in_ready=1 in the first cycle after reset release.

Configuration
REQ-028 SHALL with PID_DERIV_FILTER_EN defined use D = Kd*df, df <= df + ((err-prev_err-df)>>>2), df reset/cleared to 0.
REQ-029 SHALL without PID_DERIV_FILTER_EN use unfiltered D per REQ-019 and contain no df register.

Verification (default parameters, filter off unless stated)
REQ-030 SHALL cover: Kp=8, setpoint=100, feedback=60 -> control=80 at k+3, sat flags 0.
REQ-031 SHALL cover: Kp=8, setpoint=200, feedback=0 -> control=255, sat_hi=1; setpoint=10, feedback=50 -> control=0, sat_lo=1.
REQ-032 SHALL cover: Kp=0, Ki=4, three samples err=10 -> controls 10, 20, 30; then clr_int, err=10 -> 10.
REQ-033 SHALL cover: Ki=255, setpoint=255, feedback=0 -> integ=32767 after one sample, control=255.
REQ-034 SHALL cover: Kp=Ki=0, Kd=4, err 0 then 20 then 20 -> controls 0, 20, 0; gain write mid-sample not applied to it.
REQ-035 SHALL cover: rst_n low during ACC -> out_valid never pulses, control=0, in_ready=1 after release.
